// File: rtl/data_memory_sync_if.sv
// Request/response bundle between the MEM-stage control and data_memory_sync.
// The master drives the request fields; the slave returns load data and status.
interface data_memory_sync_if #(
   parameter int ADDR_W = 10
);
   logic              req;
   logic              WNR;
   logic [1:0]        size;
   logic              uns;
   logic [ADDR_W-1:0] address;
   logic [31:0]       in;
   logic [31:0]       out;
   logic              ready;
   logic              busy;
   logic              err;

   modport master (
      output req, WNR, size, uns, address, in,
      input  out, ready, busy, err
   );

   modport slave (
      input  req, WNR, size, uns, address, in,
      output out, ready, busy, err
   );
endinterface

// File: rtl/data_memory_sync.sv
// Synchronous byte/half/word data memory with big-endian lanes; DMEM_MISALIGN_TRAP_EN enables misalignment errors.
// Latency: ready/out/err are valid LATENCY cycles after the cycle in which req is accepted.
// Backpressure: busy is high while a request is in flight; req outside IDLE is dropped, never queued.
module data_memory_sync #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 1
) (
   input logic               clk,
   input logic               rst,
   data_memory_sync_if.slave bus
);
   localparam int         WORDS    = 2 ** (ADDR_W - 2);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
   localparam bit         LAT1     = (LATENCY == 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              wnr_q, wnr_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       din_q, din_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic [31:0]       out_q, out_d;

   // 2-state storage starts at zero and is deliberately untouched by rst.
   bit   [31:0]       mem [WORDS];

   logic              op_wnr, op_uns;
   logic [1:0]        op_size;
   logic [ADDR_W-1:0] op_addr, eff_addr;
   logic [31:0]       op_din;
   logic              misalign;
   logic              fire;
   logic [31:0]       rd_word, wr_word, load_data;
   logic [7:0]        lane8;
   logic [15:0]       lane16;

   // With LATENCY=1 the access fires on the accepting edge, so operands come straight from the bus.
   always_comb begin
      if (state_q == IDLE) begin
         op_wnr  = bus.WNR;
         op_size = bus.size;
         op_uns  = bus.uns;
         op_addr = bus.address;
         op_din  = bus.in;
      end else begin
         op_wnr  = wnr_q;
         op_size = size_q;
         op_uns  = uns_q;
         op_addr = addr_q;
         op_din  = din_q;
      end
   end

   always_comb begin
      eff_addr = op_addr;
      case (op_size)
         2'b00:   eff_addr = op_addr;
         2'b01:   eff_addr[0] = 1'b0;
         default: eff_addr[1:0] = 2'b00;
      endcase
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   assign misalign = (op_size == 2'b00) ? 1'b0 :
                     (op_size == 2'b01) ? op_addr[0] : (op_addr[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign fire = (LAT1 && state_q == IDLE && bus.req) || (state_q == WAIT && cnt_q == 4'd1);

   always_comb begin
      rd_word   = mem[eff_addr[ADDR_W-1:2]];
      wr_word   = op_din;
      load_data = rd_word;
      lane8     = 8'h00;
      lane16    = 16'h0000;
      case (op_size)
         2'b00: begin
            case (eff_addr[1:0])
               2'd0: begin lane8 = rd_word[31:24]; wr_word = {op_din[7:0], rd_word[23:0]}; end
               2'd1: begin lane8 = rd_word[23:16]; wr_word = {rd_word[31:24], op_din[7:0], rd_word[15:0]}; end
               2'd2: begin lane8 = rd_word[15:8];  wr_word = {rd_word[31:16], op_din[7:0], rd_word[7:0]}; end
               2'd3: begin lane8 = rd_word[7:0];   wr_word = {rd_word[31:8], op_din[7:0]}; end
            endcase
            load_data = {{24{~op_uns & lane8[7]}}, lane8};
         end
         2'b01: begin
            if (eff_addr[1]) begin
               lane16  = rd_word[15:0];
               wr_word = {rd_word[31:16], op_din[15:0]};
            end else begin
               lane16  = rd_word[31:16];
               wr_word = {op_din[15:0], rd_word[15:0]};
            end
            load_data = {{16{~op_uns & lane16[15]}}, lane16};
         end
         default: begin
            load_data = rd_word;
            wr_word   = op_din;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wnr_d   = wnr_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      din_d   = din_q;
      ready_d = 1'b0;
      err_d   = 1'b0;
      out_d   = out_q;
      case (state_q)
         IDLE: begin
            if (bus.req) begin
               wnr_d   = bus.WNR;
               size_d  = bus.size;
               uns_d   = bus.uns;
               addr_d  = bus.address;
               din_d   = bus.in;
               cnt_d   = CNT_INIT;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (fire) begin
         ready_d = 1'b1;
         err_d   = misalign;
         out_d   = (op_wnr || misalign) ? 32'h0 : load_data;
      end
      busy_d = (state_d == WAIT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         wnr_q   <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         din_q   <= 32'h0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         out_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wnr_q   <= wnr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         out_q   <= out_d;
      end
   end

   // The store lands on the edge that raises ready, so rst anywhere earlier in WAIT drops it.
   always_ff @(posedge clk) begin
      if (!rst && fire && op_wnr && !misalign) begin
         mem[eff_addr[ADDR_W-1:2]] <= wr_word;
      end
   end

   assign bus.out   = out_q;
   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.err   = err_q;
endmodule

// File: tb/tb_data_memory_sync.sv
// Directed bench for data_memory_sync: a LATENCY=1 instance driven from a vector table
// and a LATENCY=4 instance for throughput, ignored requests and reset abort.
module tb_data_memory_sync;
   localparam int AW = 10;
`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]         rst_v;
   logic [1:0]         req_v, wnr_v, uns_v;
   logic [1:0][1:0]    size_v;
   logic [1:0][AW-1:0] addr_v;
   logic [1:0][31:0]   din_v;
   logic [1:0][31:0]   out_s;
   logic [1:0]         rdy_s, busy_s, err_s;

   int tests = 0;
   int fails = 0;

   data_memory_sync_if #(.ADDR_W(AW)) if1 ();
   data_memory_sync_if #(.ADDR_W(AW)) if4 ();

   assign if1.req = req_v[0];  assign if1.WNR = wnr_v[0];  assign if1.size = size_v[0];
   assign if1.uns = uns_v[0];  assign if1.address = addr_v[0];  assign if1.in = din_v[0];
   assign if4.req = req_v[1];  assign if4.WNR = wnr_v[1];  assign if4.size = size_v[1];
   assign if4.uns = uns_v[1];  assign if4.address = addr_v[1];  assign if4.in = din_v[1];
   assign out_s[0] = if1.out;  assign rdy_s[0] = if1.ready;  assign busy_s[0] = if1.busy;  assign err_s[0] = if1.err;
   assign out_s[1] = if4.out;  assign rdy_s[1] = if4.ready;  assign busy_s[1] = if4.busy;  assign err_s[1] = if4.err;

   data_memory_sync #(.ADDR_W(AW), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst_v[0]), .bus(if1));
   data_memory_sync #(.ADDR_W(AW), .LATENCY(4)) u_l4 (.clk(clk), .rst(rst_v[1]), .bus(if4));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // One complete access; checks latency, busy span, result, and the idle cycle after.
   task automatic access(input int sel, input int lat, input logic w, input logic [1:0] sz,
                         input logic u, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [31:0] eo, input logic ee, input string nm);
      int cyc;
      int bcnt;
      @(negedge clk);
      req_v[sel] = 1'b1;  wnr_v[sel] = w;  size_v[sel] = sz;
      uns_v[sel] = u;     addr_v[sel] = a; din_v[sel] = d;
      cyc  = 0;
      bcnt = 0;
      do begin
         @(negedge clk);
         req_v[sel] = 1'b0;
         cyc++;
         if (busy_s[sel]) bcnt++;
      end while (!rdy_s[sel] && cyc < 40);
      chk({nm, " latency"}, 32'(cyc), 32'(lat));
      chk({nm, " busy cycles"}, 32'(bcnt), 32'(lat));
      chk({nm, " out"}, out_s[sel], eo);
      chk({nm, " err"}, 32'(err_s[sel]), 32'(ee));
      @(negedge clk);
      chk({nm, " ready drop"}, 32'(rdy_s[sel]), 32'd0);
      chk({nm, " busy drop"}, 32'(busy_s[sel]), 32'd0);
      chk({nm, " out hold"}, out_s[sel], eo);
   endtask

   typedef struct {
      logic          w;
      logic [1:0]    sz;
      logic          u;
      logic [AW-1:0] a;
      logic [31:0]   d;
      logic [31:0]   eo;
      logic          ee;
   } vec_t;

   vec_t vt[19];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vt[0]  = '{1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0};
      vt[1]  = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0};
      vt[2]  = '{1'b0, 2'b00, 1'b0, 10'h011, 32'h0, 32'hFFFFFFAD, 1'b0};
      vt[3]  = '{1'b0, 2'b00, 1'b1, 10'h011, 32'h0, 32'h000000AD, 1'b0};
      vt[4]  = '{1'b1, 2'b00, 1'b0, 10'h013, 32'h0000005A, 32'h0, 1'b0};
      vt[5]  = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'hDEADBE5A, 1'b0};
      vt[6]  = '{1'b1, 2'b10, 1'b0, 10'h010, 32'h00008001, 32'h0, 1'b0};
      vt[7]  = '{1'b0, 2'b01, 1'b0, 10'h012, 32'h0, 32'hFFFF8001, 1'b0};
      vt[8]  = '{1'b1, 2'b01, 1'b0, 10'h010, 32'h00001234, 32'h0, 1'b0};
      vt[9]  = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'h12348001, 1'b0};
      vt[10] = '{1'b0, 2'b10, 1'b0, 10'h011, 32'h0, TRAP ? 32'h0 : 32'h12348001, TRAP};
      vt[11] = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'h12348001, 1'b0};
      vt[12] = '{1'b1, 2'b01, 1'b0, 10'h011, 32'h0000BEEF, 32'h0, TRAP};
      vt[13] = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0, TRAP ? 32'h12348001 : 32'hBEEF8001, 1'b0};
      vt[14] = '{1'b0, 2'b01, 1'b1, 10'h010, 32'h0, TRAP ? 32'h00001234 : 32'h0000BEEF, 1'b0};
      vt[15] = '{1'b0, 2'b00, 1'b0, 10'h010, 32'h0, TRAP ? 32'h00000012 : 32'hFFFFFFBE, 1'b0};
      vt[16] = '{1'b0, 2'b01, 1'b1, 10'h012, 32'h0, 32'h00008001, 1'b0};
      vt[17] = '{1'b0, 2'b11, 1'b0, 10'h010, 32'h0, TRAP ? 32'h12348001 : 32'hBEEF8001, 1'b0};
      vt[18] = '{1'b0, 2'b00, 1'b0, 10'h012, 32'h0, 32'hFFFFFF80, 1'b0};

      rst_v = 2'b11;  req_v = '0;  wnr_v = '0;  uns_v = '0;
      size_v = '0;    addr_v = '0; din_v = '0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("reset dut%0d out", s), out_s[s], 32'h0);
         chk($sformatf("reset dut%0d ready", s), 32'(rdy_s[s]), 32'd0);
         chk($sformatf("reset dut%0d busy", s), 32'(busy_s[s]), 32'd0);
         chk($sformatf("reset dut%0d err", s), 32'(err_s[s]), 32'd0);
      end
      rst_v = 2'b00;

      for (int i = 0; i < 19; i++) begin
         access(0, 1, vt[i].w, vt[i].sz, vt[i].u, vt[i].a, vt[i].d, vt[i].eo, vt[i].ee,
                $sformatf("l1 vec%0d", i));
      end

      access(1, 4, 1'b1, 2'b10, 1'b0, 10'h024, 32'h11223344, 32'h0, 1'b0, "l4 store");
      access(1, 4, 1'b0, 2'b10, 1'b0, 10'h024, 32'h0, 32'h11223344, 1'b0, "l4 load");

      // req held for ten cycles: accepted in cycles 0 and 5 only.
      @(negedge clk);
      req_v[1] = 1'b1;  wnr_v[1] = 1'b0;  size_v[1] = 2'b10;  addr_v[1] = 10'h024;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("held k%0d ready", k), 32'(rdy_s[1]), 32'((k == 4) || (k == 9)));
         chk($sformatf("held k%0d busy", k), 32'(busy_s[1]),
             32'((k >= 1 && k <= 4) || (k >= 6 && k <= 9)));
         if (k == 4) chk("held k4 out", out_s[1], 32'h11223344);
      end
      req_v[1] = 1'b0;
      repeat (2) @(negedge clk);

      // req pulses during WAIT must not start a second access.
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         req_v[1] = (k == 0 || k == 2 || k == 3);
         chk($sformatf("pulse k%0d ready", k), 32'(rdy_s[1]), 32'(k == 4));
         chk($sformatf("pulse k%0d busy", k), 32'(busy_s[1]), 32'(k >= 1 && k <= 4));
      end
      req_v[1] = 1'b0;

      // Store aborted by rst in cycle 2.
      access(1, 4, 1'b0, 2'b10, 1'b0, 10'h024, 32'h0, 32'h11223344, 1'b0, "l4 pre-abort");
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (k == 0) begin
            req_v[1] = 1'b1;  wnr_v[1] = 1'b1;  size_v[1] = 2'b10;
            addr_v[1] = 10'h020;  din_v[1] = 32'hCAFEF00D;
         end else begin
            req_v[1] = 1'b0;
         end
         if (k == 2) chk("abort busy before rst", 32'(busy_s[1]), 32'd1);
         rst_v[1] = (k == 2);
         if (k == 3) begin
            chk("abort out", out_s[1], 32'h0);
            chk("abort busy", 32'(busy_s[1]), 32'd0);
            chk("abort err", 32'(err_s[1]), 32'd0);
         end
         chk($sformatf("abort k%0d ready", k), 32'(rdy_s[1]), 32'd0);
      end
      access(1, 4, 1'b0, 2'b10, 1'b0, 10'h024, 32'h0, 32'h11223344, 1'b0, "l4 post-abort other");
      access(1, 4, 1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 32'h0, 1'b0, "l4 aborted addr");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
